mlp_adc_sequencer: RTL and testbench

//  Front-end controller for the combinational printed-MLP classifier (24-bit feature bus, 2-bit class).

---
 rtl/mlp_adc_sequencer_pkg.sv | 38 +++
 rtl/mlp_adc_sequencer_counter.sv | 31 +++
 rtl/mlp_adc_sequencer.sv | 227 ++++++++++++++++++++++
 tb/tb_mlp_adc_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mlp_adc_sequencer_pkg.sv
// Shared types and helpers for the printed-MLP ADC front-end sequencer.
// Holds the FSM state encoding, default bus geometry and feature-bus slicing.
package mlp_adc_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CONVERT = 2'd2,
        ST_EVAL    = 2'd3
    } seq_state_e;

    localparam int unsigned N_FEAT_DEF = 32'd6;
    localparam int unsigned FEAT_W_DEF = 32'd4;
    localparam int unsigned CLS_W_DEF  = 32'd2;

    // Bit offset of channel idx inside the packed classifier feature bus
    function automatic int unsigned feat_lsb(input int unsigned idx, input int unsigned feat_w);
        return idx * feat_w;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/mlp_adc_sequencer_counter.sv
// Loadable down counter that times the settle, ADC-timeout and classifier-latency windows.
// One instance is shared because only one of these windows is open in any state.
module ctrl_down_counter #(
    parameter int unsigned CNT_W = 32'd4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_r;

    // Count register: load has priority, decrement stops at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (load) begin
            cnt_r <= value;
        end else if (en && (cnt_r != {CNT_W{1'b0}})) begin
            cnt_r <= cnt_r - CNT_W'(1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/mlp_adc_sequencer.sv
// Sequencer that walks one shared ADC over every sensor channel, packs the results into the
// classifier feature bus, waits for the classifier to settle and registers its class.
module mlp_adc_sequencer
    import mlp_adc_sequencer_pkg::*;
#(
    parameter int unsigned N_FEAT     = N_FEAT_DEF,
    parameter int unsigned FEAT_W     = FEAT_W_DEF,
    parameter int unsigned CLS_W      = CLS_W_DEF,
    parameter int unsigned SETTLE_CYC = 32'd2,
    parameter int unsigned CLS_LAT    = 32'd1,
    parameter int unsigned ADC_TMO    = 32'd15
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    output logic                        busy,
    output logic [$clog2(N_FEAT)-1:0]   adc_ch_sel,
    output logic                        adc_req,
    input  logic                        adc_ack,
    input  logic [FEAT_W-1:0]           adc_data,
    output logic [N_FEAT*FEAT_W-1:0]    feat_vec,
    input  logic [CLS_W-1:0]            cls_in,
    output logic [CLS_W-1:0]            class_out,
    output logic                        valid,
    output logic                        tmo_err
);

    localparam int unsigned CH_W  = $clog2(N_FEAT);
    localparam int unsigned CNT_W = $clog2(max3(SETTLE_CYC, CLS_LAT, ADC_TMO) + 32'd1);

    localparam logic [CH_W-1:0]  CH_LAST   = CH_W'(N_FEAT - 32'd1);
    // Windows last N cycles: load N-1 so the zero flag marks the final cycle
    localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 32'd1);
    localparam logic [CNT_W-1:0] TMO_LD    = CNT_W'(ADC_TMO - 32'd1);
    localparam logic [CNT_W-1:0] EVAL_LD   = CNT_W'(CLS_LAT - 32'd1);

    seq_state_e       state_r;
    seq_state_e       state_nxt_s;
    logic [CH_W-1:0]  ch_r;
    logic [CH_W-1:0]  ch_nxt_s;
    logic [FEAT_W-1:0] feat_r [N_FEAT];
    logic             busy_r;
    logic             adc_req_r;
    logic             valid_r;
    logic             tmo_err_r;
    logic [CLS_W-1:0] class_r;

    logic             cnt_load_s;
    logic [CNT_W-1:0] cnt_val_s;
    logic             cnt_en_s;
    logic             cnt_zero_s;
    logic             feat_we_s;
    logic             cls_cap_s;
    logic             tmo_set_s;
    logic             tmo_clr_s;

    ctrl_down_counter #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (cnt_load_s),
        .value (cnt_val_s),
        .en    (cnt_en_s),
        .zero  (cnt_zero_s)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; an ack in the final timeout cycle still counts as success
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nxt_s = ST_SETTLE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_CONVERT;
                end else begin
                    state_nxt_s = ST_SETTLE;
                end
            end
            ST_CONVERT: begin
                if (adc_ack) begin
                    if (ch_r == CH_LAST) begin
                        state_nxt_s = ST_EVAL;
                    end else begin
                        state_nxt_s = ST_SETTLE;
                    end
                end else if (cnt_zero_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_CONVERT;
                end
            end
            ST_EVAL: begin
                if (cnt_zero_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_EVAL;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Output/datapath decode: strobes for the registers and the shared timer
    always_comb begin
        feat_we_s = 1'b0;
        cls_cap_s = 1'b0;
        tmo_set_s = 1'b0;
        tmo_clr_s = 1'b0;
        ch_nxt_s  = ch_r;
        cnt_val_s = {CNT_W{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    tmo_clr_s = 1'b1;
                    ch_nxt_s  = {CH_W{1'b0}};
                end else begin
                    ch_nxt_s  = ch_r;
                end
            end
            ST_CONVERT: begin
                if (adc_ack) begin
                    feat_we_s = 1'b1;
                    if (ch_r != CH_LAST) begin
                        ch_nxt_s = ch_r + CH_W'(1);
                    end else begin
                        ch_nxt_s = ch_r;
                    end
                end else if (cnt_zero_s) begin
                    tmo_set_s = 1'b1;
                end else begin
                    tmo_set_s = 1'b0;
                end
            end
            ST_EVAL: begin
                if (cnt_zero_s) begin
                    cls_cap_s = 1'b1;
                end else begin
                    cls_cap_s = 1'b0;
                end
            end
            default: begin
                ch_nxt_s = ch_r;
            end
        endcase

        cnt_load_s = (state_nxt_s != state_r);
        cnt_en_s   = !cnt_load_s && (state_r != ST_IDLE);
        case (state_nxt_s)
            ST_SETTLE:  cnt_val_s = SETTLE_LD;
            ST_CONVERT: cnt_val_s = TMO_LD;
            ST_EVAL:    cnt_val_s = EVAL_LD;
            default:    cnt_val_s = {CNT_W{1'b0}};
        endcase
    end

    // Control and result registers driving the output ports
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r    <= 1'b0;
            adc_req_r <= 1'b0;
            valid_r   <= 1'b0;
            tmo_err_r <= 1'b0;
            ch_r      <= {CH_W{1'b0}};
            class_r   <= {CLS_W{1'b0}};
        end else begin
            busy_r    <= (state_nxt_s != ST_IDLE);
            adc_req_r <= (state_nxt_s == ST_CONVERT);
            valid_r   <= cls_cap_s;
            ch_r      <= ch_nxt_s;
            if (cls_cap_s) begin
                class_r <= cls_in;
            end else begin
                class_r <= class_r;
            end
            if (tmo_set_s) begin
                tmo_err_r <= 1'b1;
            end else if (tmo_clr_s) begin
                tmo_err_r <= 1'b0;
            end else begin
                tmo_err_r <= tmo_err_r;
            end
        end
    end

    // Feature register file; a channel only changes when its own conversion completes
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_FEAT; i++) begin
            if (rst) begin
                feat_r[i] <= {FEAT_W{1'b0}};
            end else if (feat_we_s && (ch_r == CH_W'(i))) begin
                feat_r[i] <= adc_data;
            end else begin
                feat_r[i] <= feat_r[i];
            end
        end
    end

    for (genvar g = 0; g < N_FEAT; g++) begin : g_pack
        assign feat_vec[feat_lsb(g, FEAT_W) +: FEAT_W] = feat_r[g];
    end

    assign busy       = busy_r;
    assign adc_req    = adc_req_r;
    assign adc_ch_sel = ch_r;
    assign valid      = valid_r;
    assign tmo_err    = tmo_err_r;
    assign class_out  = class_r;

endmodule

// File: tb/tb_mlp_adc_sequencer.sv
// Self-checking bench for mlp_adc_sequencer: randomized ADC response delays and data,
// checked against a per-inference timing/data model built from the sequencing rules.
module tb_mlp_adc_sequencer;

    localparam int N_FEAT     = 6;
    localparam int FEAT_W     = 4;
    localparam int CLS_W      = 2;
    localparam int SETTLE_CYC = 2;
    localparam int CLS_LAT    = 1;
    localparam int ADC_TMO    = 15;
    localparam int NO_ACK     = 99;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic [2:0]  adc_ch_sel;
    logic        adc_req;
    logic        adc_ack = 1'b0;
    logic [3:0]  adc_data = 4'h0;
    logic [23:0] feat_vec;
    logic [1:0]  cls_in;
    logic [1:0]  class_out;
    logic        valid;
    logic        tmo_err;

    int n_tests = 0;
    int n_fail  = 0;

    int         dly [8];
    logic [3:0] dat [8];
    int         spur_mode;
    int         inf_id;
    int         req_run = 0;
    int         run_len [8];
    int         log_id  [8];
    logic [3:0] exp_feat [N_FEAT];
    logic [1:0] exp_cls;

    mlp_adc_sequencer #(
        .N_FEAT     (N_FEAT),
        .FEAT_W     (FEAT_W),
        .CLS_W      (CLS_W),
        .SETTLE_CYC (SETTLE_CYC),
        .CLS_LAT    (CLS_LAT),
        .ADC_TMO    (ADC_TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .adc_ch_sel (adc_ch_sel),
        .adc_req    (adc_req),
        .adc_ack    (adc_ack),
        .adc_data   (adc_data),
        .feat_vec   (feat_vec),
        .cls_in     (cls_in),
        .class_out  (class_out),
        .valid      (valid),
        .tmo_err    (tmo_err)
    );

    always #5 clk = ~clk;

    // Stand-in classifier: nibble sum modulo the class count
    function automatic logic [1:0] cls_of(input logic [23:0] v);
        int s;
        s = 0;
        for (int i = 0; i < N_FEAT; i++) s += int'(v[4*i +: 4]);
        return 2'(s % 4);
    endfunction

    assign cls_in = cls_of(feat_vec);

    // ADC model: acks after dly[ch] extra request cycles, logs how long each request was held
    always @(negedge clk) begin
        if (adc_req) begin
            req_run = req_run + 1;
            run_len[adc_ch_sel] = req_run;
            log_id[adc_ch_sel]  = inf_id;
            if (req_run == dly[adc_ch_sel] + 1) begin
                adc_ack  = 1'b1;
                adc_data = dat[adc_ch_sel];
            end else begin
                adc_ack  = 1'b0;
                adc_data = 4'($urandom);
            end
        end else begin
            req_run = 0;
            if (spur_mode == 2 || (spur_mode == 1 && busy)) begin
                adc_ack  = 1'b1;
                adc_data = 4'hF;
            end else begin
                adc_ack  = 1'b0;
                adc_data = 4'($urandom);
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One inference. Sample c is the value seen by the c-th rising edge after the accept edge.
    task automatic run_inf(input bit held_in, input bit held_out, input bit noise, input string tag);
        int t;
        int ab_ch;
        int first_v;
        int vcnt;
        int exp_len;
        int got_len;
        int last_c;
        logic [23:0] exp_vec;

        ab_ch = -1;
        t = 1;
        for (int i = 0; i < N_FEAT; i++) begin
            if (ab_ch < 0) begin
                if (dly[i] >= ADC_TMO) begin
                    ab_ch = i;
                    t += SETTLE_CYC + ADC_TMO;
                end else begin
                    t += SETTLE_CYC + 1 + dly[i];
                end
            end
        end
        if (ab_ch < 0) t += CLS_LAT;
        for (int i = 0; i < N_FEAT; i++) begin
            if (ab_ch < 0 || i < ab_ch) exp_feat[i] = dat[i];
        end
        exp_vec = 24'h0;
        for (int i = 0; i < N_FEAT; i++) exp_vec = exp_vec | (24'(exp_feat[i]) << (4 * i));
        if (ab_ch < 0) exp_cls = cls_of(exp_vec);

        inf_id++;
        if (!held_in) begin
            @(negedge clk);
            start = 1'b1;
        end
        @(posedge clk);
        first_v = -1;
        vcnt    = 0;
        last_c  = held_out ? t : t + 1;
        for (int c = 1; c <= last_c; c++) begin
            @(negedge clk);
            if (valid) begin
                vcnt++;
                if (first_v < 0) first_v = c;
            end
            if (c == 1) begin
                check_eq($sformatf("%s_busy_start", tag), busy, 1'b1);
                check_eq($sformatf("%s_tmo_clr", tag), tmo_err, 1'b0);
                check_eq($sformatf("%s_ch0", tag), adc_ch_sel, 3'd0);
                check_eq($sformatf("%s_req_settle", tag), adc_req, 1'b0);
            end
            if (c == t) begin
                check_eq($sformatf("%s_busy_end", tag), busy, 1'b0);
                check_eq($sformatf("%s_tmo_err", tag), tmo_err, (ab_ch >= 0) ? 1'b1 : 1'b0);
                check_eq($sformatf("%s_feat", tag), feat_vec, exp_vec);
                check_eq($sformatf("%s_class", tag), class_out, exp_cls);
            end
            if (held_out) start = 1'b1;
            else if (c < t && noise) start = 1'($urandom_range(0, 1));
            else start = 1'b0;
        end
        check_eq($sformatf("%s_valid_cyc", tag), first_v, (ab_ch < 0) ? t : -1);
        check_eq($sformatf("%s_valid_cnt", tag), vcnt, (ab_ch < 0) ? 1 : 0);
        for (int i = 0; i < N_FEAT; i++) begin
            if (ab_ch < 0 || i < ab_ch) exp_len = dly[i] + 1;
            else if (i == ab_ch) exp_len = ADC_TMO;
            else exp_len = 0;
            got_len = (log_id[i] == inf_id) ? run_len[i] : 0;
            check_eq($sformatf("%s_req_len%0d", tag, i), got_len, exp_len);
        end
    endtask

    initial begin
        bit found;
        rst       = 1'b1;
        start     = 1'b0;
        spur_mode = 0;
        inf_id    = 0;
        exp_cls   = 2'd0;
        for (int i = 0; i < 8; i++) begin
            dly[i]     = 0;
            dat[i]     = 4'h0;
            run_len[i] = 0;
            log_id[i]  = -1;
        end
        for (int i = 0; i < N_FEAT; i++) exp_feat[i] = 4'h0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("rst_req", adc_req, 1'b0);
        check_eq("rst_valid", valid, 1'b0);
        check_eq("rst_tmo", tmo_err, 1'b0);
        check_eq("rst_ch", adc_ch_sel, 3'd0);
        check_eq("rst_feat", feat_vec, 24'h0);
        check_eq("rst_class", class_out, 2'd0);
        rst = 1'b0;

        // Nominal: every channel acks at once, channel i returns i+1
        for (int i = 0; i < N_FEAT; i++) dat[i] = 4'(i + 1);
        run_inf(1'b0, 1'b0, 1'b0, "nominal");
        check_eq("nominal_feat_const", feat_vec, 24'h654321);

        // Channel 2 acks three cycles late
        for (int i = 0; i < N_FEAT; i++) dat[i] = 4'($urandom);
        dly[2] = 3;
        run_inf(1'b0, 1'b0, 1'b0, "ack_dly3");

        // Ack in the very cycle the timeout expires still succeeds
        dly[2] = 0;
        dly[1] = ADC_TMO - 1;
        for (int i = 0; i < N_FEAT; i++) dat[i] = 4'($urandom);
        run_inf(1'b0, 1'b0, 1'b1, "ack_last");

        // Channel 4 never acks; the following start clears the sticky flag
        dly[1] = 0;
        dly[4] = NO_ACK;
        for (int i = 0; i < N_FEAT; i++) dat[i] = 4'($urandom);
        run_inf(1'b0, 1'b0, 1'b1, "timeout");
        dly[4] = 0;
        for (int i = 0; i < N_FEAT; i++) dat[i] = 4'($urandom);
        run_inf(1'b0, 1'b0, 1'b0, "after_tmo");

        // start held high: back-to-back inferences
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N_FEAT; i++) begin
                dat[i] = 4'($urandom);
                dly[i] = int'($urandom_range(0, 2));
            end
            run_inf(k != 0, k != 2, 1'b0, $sformatf("held%0d", k));
        end

        // Reset while channel 3 is converting
        for (int i = 0; i < N_FEAT; i++) dly[i] = 0;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 100 && !found; c++) begin
            if (adc_req && adc_ch_sel == 3'd3) found = 1'b1;
            else @(negedge clk);
        end
        check_eq("rst_mid_reach", found, 1'b1);
        rst = 1'b1;
        @(negedge clk);
        check_eq("rst_mid_busy", busy, 1'b0);
        check_eq("rst_mid_req", adc_req, 1'b0);
        check_eq("rst_mid_feat", feat_vec, 24'h0);
        check_eq("rst_mid_valid", valid, 1'b0);
        rst = 1'b0;
        for (int i = 0; i < N_FEAT; i++) exp_feat[i] = 4'h0;
        exp_cls = 2'd0;
        spur_mode = 2;
        repeat (4) @(negedge clk);
        check_eq("idle_spur_feat", feat_vec, 24'h0);
        check_eq("idle_spur_busy", busy, 1'b0);
        check_eq("idle_spur_valid", valid, 1'b0);
        spur_mode = 0;

        // Spurious acks with 4'hF during SETTLE and EVAL
        spur_mode = 1;
        for (int i = 0; i < N_FEAT; i++) begin
            dat[i] = 4'($urandom_range(0, 14));
            dly[i] = int'($urandom_range(0, 3));
        end
        run_inf(1'b0, 1'b0, 1'b1, "spur");
        spur_mode = 0;

        // Randomized inferences, occasional timeout and last-cycle acks
        for (int k = 0; k < 14; k++) begin
            for (int i = 0; i < N_FEAT; i++) begin
                int r;
                r = int'($urandom_range(0, 19));
                if (r == 0) dly[i] = NO_ACK;
                else if (r == 1) dly[i] = ADC_TMO - 1;
                else dly[i] = int'($urandom_range(0, 3));
                dat[i] = 4'($urandom);
            end
            spur_mode = int'($urandom_range(0, 1));
            run_inf(1'b0, 1'b0, 1'($urandom_range(0, 1)), $sformatf("rand%0d", k));
        end
        spur_mode = 0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
